pipe_bpred: RTL and testbench
=============================

# pipe_bpred

Parametrised dynamic branch predictor for the five-stage pipelined CPU. It replaces the current policy of always bubbling on a taken branch or jump with a direct-mapped table of 2-bit saturating counters. IF queries the table with the fetch PC, and the predicted direction is returned with the instruction in ID. ID, which resolves beq/bne early using the forwarded register compare, reports the actual outcome. The block updates the table, flags mispredicts so the pipeline can flush, and keeps saturating statistics counters.

## Interface
Parameters:
- ADDR_W, 32, PC width.
- IDX_W, 6, table index width; the table has 2^IDX_W entries.
- CNT_INIT, 2'b01, counter value written during init (weakly not-taken).
- STAT_W, 16, width of each statistics counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- ready  out  1  table initialised; lookups and updates are valid.
- lk_valid  in  1  IF lookup request.
- lk_stall  in  1  pipeline stall (wpcir low); holds the prediction output.
- lk_pc  in  ADDR_W  fetch PC.
- pred_taken  out  1  registered prediction for the last accepted lookup.
- rs_valid  in  1  ID has resolved a conditional branch this cycle.
- rs_pc  in  ADDR_W  PC of the resolved branch.
- rs_taken  in  1  actual outcome (register_eq-based).
- rs_pred  in  1  prediction carried with that branch.
- mispredict  out  1  combinational: the pipeline must flush and redirect.
- n_branch  out  STAT_W  resolved-branch count.
- n_miss  out  STAT_W  mispredict count.

## Operation
- Index is pc[IDX_W+1:2]; pc[1:0] are ignored. There are no tags, so aliasing is permitted.
- FSM states are INIT and RUN.
- Reset enters INIT. init_ptr goes to 0, and ready, pred_taken, n_branch and n_miss all go to 0.
- INIT: write CNT_INIT to entry init_ptr and increment init_ptr. When the entry 2^IDX_W-1 write completes, move to RUN and set ready=1.
- While in INIT, lookups and updates are ignored and mispredict is 0.
- RUN, lookup: if lk_valid && !lk_stall, then pred_taken <= counter[idx(lk_pc)][1] on the next edge.
  - If lk_stall=1, pred_taken holds.
  - If lk_valid=0 and lk_stall=0, pred_taken <= 0.
- RUN, update: if rs_valid, counter[idx(rs_pc)] is incremented when rs_taken and decremented otherwise.
  - The counter saturates at 3 and 0.
- Same-index collision: a lookup and an update to the same index in the same cycle produce a prediction from the post-update counter value (write bypass).
- mispredict = ready & rs_valid & (rs_taken != rs_pred).
- Statistics:
  - n_branch increments on every RUN cycle with rs_valid.
  - n_miss increments whenever mispredict is 1.
  - Both saturate at all-ones and never wrap.
- Reset asserted while in RUN or mid-INIT restarts INIT from entry 0 and clears all statistics.

## Timing
- Init takes 2^IDX_W cycles after reset deasserts. ready rises on the cycle after the final init write (64 cycles for IDX_W=6).
- Lookup latency is 1 cycle: lk_pc is sampled on edge N and pred_taken is valid after edge N, in step with the IF/ID register.
- An update is visible to a lookup issued in the same cycle (bypass) and to any later lookup.
- mispredict has 0-cycle latency (combinational from the rs_* inputs). The flush takes effect on the next edge.
- Statistics update on the edge following rs_valid.

## Test plan
- Init:
  - Stimulus: pulse reset, then count cycles.
  - Required: ready=0 for 64 cycles, then 1.
  - Required: lookups of any PC return pred_taken=0 (CNT_INIT=01).
- Training:
  - Stimulus: pc=0x0040_0010, two updates with rs_taken=1, then a lookup.
  - Required: pred_taken=1.
  - Stimulus: three more taken updates, then one not-taken update.
  - Required: pred_taken stays 1 (3 -> 2).
  - Stimulus: one further not-taken update.
  - Required: pred_taken=0.
- Aliasing and bypass:
  - Stimulus: update pc=0x10 (taken) in the same cycle as a lookup of pc=0x110 (same index at IDX_W=6), starting from counter=01.
  - Required: pred_taken=1 on the next cycle.
- Mispredict and stall:
  - Stimulus: rs_valid=1, rs_taken=1, rs_pred=0.
  - Required: mispredict=1 in the same cycle; n_miss goes 0 -> 1 and n_branch goes 0 -> 1.
  - Stimulus: lk_stall=1 for 3 cycles with a changing lk_pc.
  - Required: pred_taken is unchanged.
- Statistics saturation:
  - Stimulus: STAT_W=4, 20 resolved mispredicts.
  - Required: n_branch=n_miss=15 (saturated, no wrap).
- Reset mid-operation:
  - Stimulus: assert reset at init_ptr=30, then after training.
  - Required: ready drops, a full 64-cycle init reruns, and all counters read back as CNT_INIT.
  - Required: statistics read 0.

Source files
------------

// File: rtl/pipe_bpred.sv
// rtl/pipe_bpred.sv - direct-mapped 2-bit saturating-counter branch predictor
module pipe_bpred #(
  parameter int         ADDR_W   = 32,
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         STAT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic              ready,
  input  logic              lk_valid,
  input  logic              lk_stall,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              pred_taken,
  input  logic              rs_valid,
  input  logic [ADDR_W-1:0] rs_pc,
  input  logic              rs_taken,
  input  logic              rs_pred,
  output logic              mispredict,
  output logic [STAT_W-1:0] n_branch,
  output logic [STAT_W-1:0] n_miss
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  init_ptr_q;
  logic [1:0]        cnt_q [DEPTH];
  logic              ready_q;
  logic              pred_q;
  logic [STAT_W-1:0] n_branch_q, n_branch_d;
  logic [STAT_W-1:0] n_miss_q, n_miss_d;

  logic [IDX_W-1:0]  lk_idx, rs_idx;
  logic [1:0]        rs_cnt, rs_cnt_d, lk_cnt;
  logic              upd_en;
  logic              unused_pc_bits;

  assign lk_idx = lk_pc[IDX_W+1:2];
  assign rs_idx = rs_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{lk_pc[ADDR_W-1:IDX_W+2], lk_pc[1:0],
                            rs_pc[ADDR_W-1:IDX_W+2], rs_pc[1:0]};

  assign upd_en     = (state_q == ST_RUN) && rs_valid;
  assign mispredict = ready_q & rs_valid & (rs_taken != rs_pred);

  // A lookup that hits the index being updated sees the post-update counter.
  always_comb begin
    rs_cnt   = cnt_q[rs_idx];
    rs_cnt_d = rs_cnt;
    if (rs_taken) begin
      if (rs_cnt != 2'b11) rs_cnt_d = rs_cnt + 2'b01;
    end else begin
      if (rs_cnt != 2'b00) rs_cnt_d = rs_cnt - 2'b01;
    end
    lk_cnt = cnt_q[lk_idx];
    if (rs_valid && (rs_idx == lk_idx)) lk_cnt = rs_cnt_d;
  end

  always_comb begin
    n_branch_d = n_branch_q;
    n_miss_d   = n_miss_q;
    if (upd_en && (n_branch_q != {STAT_W{1'b1}})) n_branch_d = n_branch_q + STAT_W'(1);
    if (mispredict && (n_miss_q != {STAT_W{1'b1}})) n_miss_d = n_miss_q + STAT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == ST_INIT) cnt_q[init_ptr_q] <= CNT_INIT;
      else if (rs_valid) cnt_q[rs_idx] <= rs_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      ready_q    <= 1'b0;
      pred_q     <= 1'b0;
      n_branch_q <= '0;
      n_miss_q   <= '0;
    end else if (state_q == ST_INIT) begin
      init_ptr_q <= init_ptr_q + IDX_W'(1);
      if (init_ptr_q == {IDX_W{1'b1}}) begin
        state_q <= ST_RUN;
        ready_q <= 1'b1;
      end
    end else begin
      if (!lk_stall) pred_q <= lk_valid & lk_cnt[1];
      n_branch_q <= n_branch_d;
      n_miss_q   <= n_miss_d;
    end
  end

  assign ready      = ready_q;
  assign pred_taken = pred_q;
  assign n_branch   = n_branch_q;
  assign n_miss     = n_miss_q;

endmodule

// File: tb/tb_pipe_bpred.sv
// tb/tb_pipe_bpred.sv - scoreboard bench for pipe_bpred
module tb_pipe_bpred;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 6;
  localparam int STAT_W = 4;

  localparam int S_RDY  = 0;
  localparam int S_PRED = 1;
  localparam int S_MISP = 2;
  localparam int S_NB   = 3;
  localparam int S_NM   = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              ready;
  logic              lk_valid, lk_stall;
  logic [ADDR_W-1:0] lk_pc;
  logic              pred_taken;
  logic              rs_valid, rs_taken, rs_pred;
  logic [ADDR_W-1:0] rs_pc;
  logic              mispredict;
  logic [STAT_W-1:0] n_branch, n_miss;

  pipe_bpred #(
    .ADDR_W(ADDR_W), .IDX_W(IDX_W), .CNT_INIT(2'b01), .STAT_W(STAT_W)
  ) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .lk_valid(lk_valid), .lk_stall(lk_stall), .lk_pc(lk_pc),
    .pred_taken(pred_taken),
    .rs_valid(rs_valid), .rs_pc(rs_pc), .rs_taken(rs_taken), .rs_pred(rs_pred),
    .mispredict(mispredict), .n_branch(n_branch), .n_miss(n_miss)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    int due;
    int sel;
    int val;
    int tag;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   tag   = 0;

  function automatic string sel_name(input int sel);
    case (sel)
      S_RDY:   return "ready";
      S_PRED:  return "pred_taken";
      S_MISP:  return "mispredict";
      S_NB:    return "n_branch";
      default: return "n_miss";
    endcase
  endfunction

  function automatic int actual(input int sel);
    case (sel)
      S_RDY:   return int'(ready);
      S_PRED:  return int'(pred_taken);
      S_MISP:  return int'(mispredict);
      S_NB:    return int'(n_branch);
      default: return int'(n_miss);
    endcase
  endfunction

  // Monitor: retire every expectation that has come due at this sampling point.
  always @(negedge clock) begin
    exp_t e;
    int   act;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e     = sbq.pop_front();
      act   = actual(e.sel);
      total = total + 1;
      if (act != e.val) begin
        bad = bad + 1;
        $display("FAIL %s tag=%0d got=%0d want=%0d", sel_name(e.sel), e.tag, act, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_now(input int sel, input int val);
    sbq.push_back('{due: cyc, sel: sel, val: val, tag: tag});
  endtask

  task automatic exp_next(input int sel, input int val);
    sbq.push_back('{due: cyc + 1, sel: sel, val: val, tag: tag});
  endtask

  task automatic set_lk(input logic v, input logic s, input logic [ADDR_W-1:0] pc);
    lk_valid = v;
    lk_stall = s;
    lk_pc    = pc;
  endtask

  task automatic set_rs(input logic v, input logic [ADDR_W-1:0] pc, input logic t, input logic p);
    rs_valid = v;
    rs_pc    = pc;
    rs_taken = t;
    rs_pred  = p;
  endtask

  localparam logic [ADDR_W-1:0] PC_A = 32'h0040_0010;

  initial begin
    set_lk(1'b0, 1'b0, '0);
    set_rs(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Init: lookups and resolutions must be ignored for 64 cycles
    set_lk(1'b1, 1'b0, 32'h10);
    set_rs(1'b1, 32'h10, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      tag = i;
      exp_now(S_RDY, 0); exp_now(S_MISP, 0); exp_now(S_PRED, 0);
      step();
    end
    tag = 100;
    set_lk(1'b0, 1'b0, '0);
    set_rs(1'b0, '0, 1'b0, 1'b0);
    exp_now(S_RDY, 1); exp_now(S_NB, 0); exp_now(S_NM, 0); exp_now(S_PRED, 0);
    step();

    tag = 110; set_lk(1'b1, 1'b0, 32'h0);         exp_next(S_PRED, 0); step();
    tag = 111; set_lk(1'b1, 1'b0, 32'hFFFF_FFFC); exp_next(S_PRED, 0); step();
    tag = 112; set_lk(1'b1, 1'b0, 32'h10);        exp_next(S_PRED, 0); step();

    // Mispredict flag and statistics, index 0 goes 01->10->11->10
    set_lk(1'b0, 1'b0, '0);
    tag = 200; set_rs(1'b1, 32'h200, 1'b1, 1'b0);
    exp_now(S_MISP, 1); exp_next(S_NB, 1); exp_next(S_NM, 1); step();
    tag = 201; set_rs(1'b1, 32'h200, 1'b1, 1'b1);
    exp_now(S_MISP, 0); exp_next(S_NB, 2); exp_next(S_NM, 1); step();
    tag = 202; set_rs(1'b1, 32'h200, 1'b0, 1'b1);
    exp_now(S_MISP, 1); exp_next(S_NB, 3); exp_next(S_NM, 2); step();
    tag = 203; set_rs(1'b0, 32'h200, 1'b1, 1'b0);
    exp_now(S_MISP, 0); exp_next(S_NB, 3); exp_next(S_NM, 2); step();

    // Stall holds the prediction
    set_rs(1'b0, '0, 1'b0, 1'b0);
    tag = 300; set_lk(1'b1, 1'b0, 32'h0); exp_next(S_PRED, 1); step();
    tag = 301; set_lk(1'b1, 1'b1, 32'h4); exp_next(S_PRED, 1); step();
    tag = 302; set_lk(1'b0, 1'b1, 32'h8); exp_next(S_PRED, 1); step();
    tag = 303; set_lk(1'b1, 1'b1, 32'hC); exp_next(S_PRED, 1); step();
    tag = 304; set_lk(1'b0, 1'b0, 32'h4); exp_next(S_PRED, 0); step();

    // Training on PC_A
    set_lk(1'b0, 1'b0, '0);
    tag = 400; set_rs(1'b1, PC_A, 1'b1, 1'b1); exp_next(S_NB, 4); step();
    tag = 401; set_rs(1'b1, PC_A, 1'b1, 1'b1); exp_next(S_NB, 5); step();
    tag = 402; set_rs(1'b0, '0, 1'b0, 1'b0); set_lk(1'b1, 1'b0, PC_A); exp_next(S_PRED, 1); step();
    set_lk(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      tag = 410 + i; set_rs(1'b1, PC_A, 1'b1, 1'b1); exp_next(S_NB, 6 + i); step();
    end
    tag = 420; set_rs(1'b1, PC_A, 1'b0, 1'b0); exp_next(S_NB, 9); step();
    tag = 421; set_rs(1'b0, '0, 1'b0, 1'b0); set_lk(1'b1, 1'b0, PC_A); exp_next(S_PRED, 1); step();
    tag = 422; set_lk(1'b0, 1'b0, '0); set_rs(1'b1, PC_A, 1'b0, 1'b0); exp_next(S_NB, 10); step();
    tag = 423; set_rs(1'b0, '0, 1'b0, 1'b0); set_lk(1'b1, 1'b0, PC_A);
    exp_now(S_NM, 2); exp_next(S_PRED, 0); step();

    // Aliased same-cycle update and lookup use the bypassed value
    tag = 500; set_rs(1'b1, 32'h10, 1'b1, 1'b1); set_lk(1'b1, 1'b0, 32'h110);
    exp_next(S_PRED, 1); exp_next(S_NB, 11); step();
    tag = 501; set_rs(1'b1, 32'h10, 1'b0, 1'b0); set_lk(1'b1, 1'b0, 32'h110);
    exp_next(S_PRED, 0); exp_next(S_NB, 12); step();

    // Counter floor at 0
    set_lk(1'b0, 1'b0, '0);
    tag = 600; set_rs(1'b1, 32'h8, 1'b0, 1'b0); exp_next(S_NB, 13); step();
    tag = 601; set_rs(1'b1, 32'h8, 1'b0, 1'b0); exp_next(S_NB, 14); step();
    tag = 602; set_rs(1'b1, 32'h8, 1'b1, 1'b1); exp_next(S_NB, 15); step();
    tag = 603; set_rs(1'b0, '0, 1'b0, 1'b0); set_lk(1'b1, 1'b0, 32'h8); exp_next(S_PRED, 0); step();
    tag = 604; set_lk(1'b0, 1'b0, '0); set_rs(1'b1, 32'h8, 1'b1, 1'b1); exp_next(S_NB, 15); step();
    tag = 605; set_rs(1'b0, '0, 1'b0, 1'b0); set_lk(1'b1, 1'b0, 32'h8); exp_next(S_PRED, 1); step();

    // Statistics saturation with 20 mispredicts
    set_lk(1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) begin
      tag = 700 + i;
      set_rs(1'b1, 32'h40, 1'b1, 1'b0);
      exp_now(S_MISP, 1); exp_next(S_NB, 15); exp_next(S_NM, (i + 3 > 15) ? 15 : i + 3);
      step();
    end
    tag = 720; set_rs(1'b0, '0, 1'b0, 1'b0); exp_now(S_NB, 15); exp_now(S_NM, 15); step();

    // Reset from RUN, then again at init_ptr=30
    reset = 1'b1; step(); reset = 1'b0;
    set_rs(1'b1, 32'h40, 1'b1, 1'b0);
    set_lk(1'b1, 1'b0, 32'h40);
    tag = 800; exp_now(S_NB, 0); exp_now(S_NM, 0);
    for (int i = 0; i < 30; i++) begin
      tag = 810 + i;
      exp_now(S_RDY, 0); exp_now(S_MISP, 0); exp_now(S_PRED, 0);
      step();
    end
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tag = 900 + i;
      exp_now(S_RDY, 0); exp_now(S_MISP, 0); exp_now(S_PRED, 0);
      step();
    end
    tag = 1000; set_rs(1'b0, '0, 1'b0, 1'b0); set_lk(1'b0, 1'b0, '0);
    exp_now(S_RDY, 1); exp_now(S_NB, 0); exp_now(S_NM, 0);

    // Every entry must be back at 01: taken gives 10 (predict 1), not-taken returns to 01 (predict 0)
    for (int i = 0; i < 64; i++) begin
      logic [ADDR_W-1:0] pc;
      pc  = 32'h0040_0000 + ADDR_W'(i * 4);
      tag = 1100 + i;
      set_rs(1'b1, pc, 1'b1, 1'b1); set_lk(1'b1, 1'b0, pc); exp_next(S_PRED, 1); step();
      set_rs(1'b1, pc, 1'b0, 1'b0); set_lk(1'b1, 1'b0, pc); exp_next(S_PRED, 0); step();
    end
    tag = 1200; set_rs(1'b0, '0, 1'b0, 1'b0); set_lk(1'b0, 1'b0, '0);
    exp_now(S_NB, 15); exp_now(S_NM, 0);

    for (int i = 0; i < 4; i++) begin
      if (sbq.size() > 0) step();
    end
    if (sbq.size() > 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL drain pending=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
